evm_ballot_unit: RTL
====================

Name: evm_ballot_unit

Overview:
Voter-facing ballot unit that sources the vote code consumed by the EVM tally counter. The presiding officer's control unit arms the unit once per voter. The unit then accepts exactly one debounced single-button press and emits the candidate number on `vote` for exactly one clock. All other times `vote` holds an out-of-range idle code, so the downstream counter never increments spuriously.

Parameters:
- NUM_CAND, 10, number of candidate buttons (2..15); codes 0..NUM_CAND-1.
- DEBOUNCE_CYCLES, 4, consecutive clock edges a single button must be seen before the vote is accepted (>=1).
- TIMEOUT_CYCLES, 1000, clock edges allowed in ARMED/DEBOUNCE before the ballot is abandoned (>=DEBOUNCE_CYCLES+1).
- IDLE_CODE, 4'hF, value driven on `vote` when no vote is being cast (must be >= NUM_CAND).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ballot_enable  in  1  arm request from the control unit; sampled only in IDLE.
- buttons  in  NUM_CAND  candidate buttons, active-high, already synchronised to clk.
- vote  out  4  candidate code for one cycle on a cast; IDLE_CODE otherwise. Connects to the tally counter vote input.
- vote_valid  out  1  high exactly in the cast cycle.
- ready_lamp  out  1  high in ARMED and DEBOUNCE.
- busy_lamp  out  1  high in CAST and RELEASE (voter "beep" lamp).
- timeout  out  1  one-cycle pulse when an armed ballot expires without a vote.
- voters_count  out  16  total votes cast since reset; saturates at 16'hFFFF.

Behaviour:
- Clock and reset: clk is the clock. reset is asynchronous, active-high.
- Reset values: state=IDLE, vote=IDLE_CODE, vote_valid=0, ready_lamp=0, busy_lamp=0, timeout=0, voters_count=0, debounce/timeout counters=0.
- Registers: all outputs are registered; lamps are decoded from the registered state.
- Single-press term: `onehot` means exactly one bit of `buttons` is set; `sel` is that bit's index.
- IDLE:
  - ballot_enable=1 -> ARMED; timer cleared.
  - Buttons are ignored.
- ARMED:
  - onehot -> DEBOUNCE, dcnt=1, latch sel.
  - Zero buttons or more than one button -> stay ARMED (multi-press is never accepted).
  - If DEBOUNCE_CYCLES=1, onehot goes directly to CAST.
- DEBOUNCE, on each edge:
  - Same single button still pressed: dcnt+1; when dcnt+1==DEBOUNCE_CYCLES -> CAST.
  - Any other pattern (release, different button, extra button) -> ARMED, dcnt=0; timer keeps running.
- CAST (exactly one cycle):
  - vote=latched sel, vote_valid=1.
  - voters_count+1, saturating.
  - Next edge -> RELEASE.
- RELEASE:
  - Wait until buttons==0, then -> IDLE.
  - A held button can never produce a second vote; a new vote requires a new ballot_enable.
- Latency: a single button first seen at edge k produces vote_valid high in the cycle following edge k+DEBOUNCE_CYCLES-1.
- Timeout:
  - timer increments on every edge in ARMED/DEBOUNCE.
  - At the edge where timer==TIMEOUT_CYCLES-1 and no transition to CAST occurs: -> IDLE, timeout=1 for one cycle, no vote, voters_count unchanged.
  - If that edge also completes debounce, CAST wins and no timeout pulse is produced.
- Ignored enables: ballot_enable outside IDLE is ignored and is not queued.
- Reset mid-operation (any state, including CAST): immediate return to reset values; a vote in flight is dropped.

Test Plan:
- Reset, pulse ballot_enable, hold buttons=10'b00_0000_1000 -> exactly one cycle with vote=3, vote_valid=1, 4 edges after first press is seen. voters_count=1; vote=4'hF at all other times.
- Armed, press buttons=0x003 (two buttons) for 50 cycles, then 0x200 -> no vote during the multi-press; then vote=9 once.
- Armed, glitch button 5 for 2 cycles, release, then press button 5 steadily -> no vote from the glitch; single vote=5 after a full DEBOUNCE_CYCLES run.
- Hold button 2 for 200 cycles after a cast, with ballot_enable pulsed during RELEASE -> only one vote; enable ignored; return to IDLE after release.
- TIMEOUT_CYCLES=20, arm, no buttons -> timeout pulse exactly at edge 20, state=IDLE, voters_count unchanged, no vote.
- Assert reset while in DEBOUNCE on button 7 -> all outputs at reset values; no vote=7 ever appears; the next ballot works normally.

Source files
------------

// File: rtl/evm_ballot_unit.sv
// Voter-facing ballot unit. It is armed once per voter, accepts one debounced
// single-button press, and presents the candidate code on vote for exactly
// one clock. At all other times vote carries IDLE_CODE so the tally counter
// never counts by accident.
module evm_ballot_unit #(
  parameter int          NUM_CAND        = 10,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter int          TIMEOUT_CYCLES  = 1000,
  parameter logic [3:0]  IDLE_CODE       = 4'hF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ballot_enable,
  input  logic [NUM_CAND-1:0] buttons,
  output logic [3:0]          vote,
  output logic                vote_valid,
  output logic                ready_lamp,
  output logic                busy_lamp,
  output logic                timeout,
  output logic [15:0]         voters_count
);

  localparam int DW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ARMED, DEBOUNCE, CAST, RELEASE} state_t;

  state_t        state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0]    sel, sel_n;
  logic          cast_n, timeout_n;
  logic          onehot;
  logic [3:0]    idx;

  // Index of the highest set button; only meaningful when exactly one is set.
  function automatic logic [3:0] button_index(input logic [NUM_CAND-1:0] b);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (b[i]) r = 4'(i);
    end
    return r;
  endfunction

  assign onehot = (buttons != '0) && ((buttons & (buttons - 1'b1)) == '0);
  assign idx    = button_index(buttons);

  // Lamps are a pure decode of the registered state.
  assign ready_lamp = (state == ARMED) || (state == DEBOUNCE);
  assign busy_lamp  = (state == CAST) || (state == RELEASE);

  // State and ballot bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dcnt  <= '0;
      timer <= '0;
      sel   <= '0;
    end else begin
      state <= state_n;
      dcnt  <= dcnt_n;
      timer <= timer_n;
      sel   <= sel_n;
    end
  end

  // Next-state logic; a completed debounce takes priority over expiry.
  always_comb begin
    state_n   = state;
    dcnt_n    = dcnt;
    timer_n   = timer;
    sel_n     = sel;
    cast_n    = 1'b0;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        if (ballot_enable) begin
          state_n = ARMED;
          timer_n = '0;
          dcnt_n  = '0;
        end
      end
      ARMED: begin
        timer_n = timer + 1'b1;
        if (onehot) begin
          sel_n = idx;
          if (DEBOUNCE_CYCLES == 1) begin
            state_n = CAST;
            cast_n  = 1'b1;
          end else begin
            state_n = DEBOUNCE;
            dcnt_n  = DW'(1);
          end
        end
        if (!cast_n && timer == TW'(TIMEOUT_CYCLES - 1)) begin
          state_n   = IDLE;
          dcnt_n    = '0;
          timeout_n = 1'b1;
        end
      end
      DEBOUNCE: begin
        timer_n = timer + 1'b1;
        if (onehot && idx == sel) begin
          if ((dcnt + 1'b1) == DW'(DEBOUNCE_CYCLES)) begin
            state_n = CAST;
            cast_n  = 1'b1;
          end else begin
            dcnt_n = dcnt + 1'b1;
          end
        end else begin
          state_n = ARMED;
          dcnt_n  = '0;
        end
        if (!cast_n && timer == TW'(TIMEOUT_CYCLES - 1)) begin
          state_n   = IDLE;
          dcnt_n    = '0;
          timeout_n = 1'b1;
        end
      end
      CAST: begin
        state_n = RELEASE;
        dcnt_n  = '0;
      end
      RELEASE: begin
        if (buttons == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered outputs; vote and count update on the edge that enters CAST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vote         <= IDLE_CODE;
      vote_valid   <= 1'b0;
      timeout      <= 1'b0;
      voters_count <= '0;
    end else begin
      vote       <= cast_n ? sel_n : IDLE_CODE;
      vote_valid <= cast_n;
      timeout    <= timeout_n;
      if (cast_n && voters_count != 16'hFFFF) voters_count <= voters_count + 16'd1;
    end
  end

endmodule
